// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : if_pkg
// Purpose  : Shared types and constants for the instruction fetch stage:
//            fetch FSM state encoding, default bubble word, PC increment and
//            the {pc, instr, valid} entry used by the IF/ID register and the
//            freeze buffer.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Opcode 0 decodes as a no-op, so an all-zero word is a safe bubble.
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP   = 32'd4;

    // FETCH : request outstanding for pc
    // HOLD  : word fetched while frozen, parked in the buffer, no request
    // DRAIN : request outstanding whose data belongs to a squashed path
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;     // PC+4 of the instruction
        logic [31:0] instr;  // instruction word
        logic        valid;  // 0 = bubble
    } if_entry_t;

    function automatic if_entry_t make_bubble(input logic [31:0] nop_word);
        if_entry_t e;
        e.pc    = '0;
        e.instr = nop_word;
        e.valid = 1'b0;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : if_stage_if
// Purpose   : Instruction memory request/acknowledge bus.
// Signals   : imem_req   - fetch request, held until imem_ack
//             imem_addr  - fetch address, stable while imem_req is high
//             imem_ack   - one-cycle pulse retiring the outstanding request
//             imem_rdata - instruction word, valid with imem_ack
// Modports  : master (fetch stage), slave (instruction memory)
// Revision  : 1.0 - initial release
// ============================================================================
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : 65-bit IF/ID pipeline register {pc, instr, valid} with
//            flush / load / hold control. Reset and flush both produce a
//            bubble; flush has priority over load.
// Ports    : clk     - clock
//            rst     - synchronous active-high reset
//            i_load  - capture i_d
//            i_flush - replace contents with a bubble
//            i_d     - next entry
//            o_q     - current entry
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_load,
    input  wire logic      i_flush,
    input  wire if_entry_t i_d,
    output if_entry_t      o_q
);

    if_entry_t r_q;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_q <= make_bubble(NOP_INSTR);
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage. Owns the PC, fetches from instruction
//            memory over a variable-latency req/ack handshake and feeds the
//            IF/ID register. Stalls on freeze, flushes and redirects on a
//            taken branch, and inserts NOP bubbles when no word is ready.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            freeze          - hazard stall (IF/ID holds, PC holds)
//            br_taken/br_addr- taken branch from EXE and its target
//            imem            - instruction memory bus (master side)
//            if_pc           - PC+4 of the instruction in IF/ID
//            if_instruction  - instruction word to decode
//            if_valid        - IF/ID holds a real instruction
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        freeze,
    input  wire logic        br_taken,
    input  wire logic [31:0] br_addr,
    if_stage_if.master       imem,
    output logic      [31:0] if_pc,
    output logic      [31:0] if_instruction,
    output logic             if_valid
);

    if_state_e   r_state;
    if_state_e   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_drain_addr;       // address of the squashed request
    logic [31:0] w_drain_addr_next;
    if_entry_t   r_buf;              // word fetched while frozen
    if_entry_t   w_buf_next;

    logic        w_req;
    logic        w_ack;
    logic [31:0] w_pc_inc;
    if_entry_t   w_fetched;
    if_entry_t   w_ifid_d;
    if_entry_t   w_ifid_q;
    logic        w_ifid_load;
    logic        w_ifid_flush;

    // No request in HOLD or during reset; an ack without a request is noise.
    assign w_req    = !rst && (r_state != HOLD);
    assign w_ack    = imem.imem_ack && w_req;
    assign w_pc_inc = r_pc + c_PC_STEP;

    assign w_fetched.pc    = w_pc_inc;
    assign w_fetched.instr = imem.imem_rdata;
    assign w_fetched.valid = 1'b1;

    assign imem.imem_req  = w_req;
    // In DRAIN the PC already points at the branch target, but the memory
    // must keep seeing the address of the request it is still serving.
    assign imem.imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_buf        <= make_bubble(NOP_INSTR);
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_drain_addr <= w_drain_addr_next;
            r_buf        <= w_buf_next;
        end
    end

    // Event priority: br_taken > freeze > normal flow.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_drain_addr_next = r_drain_addr;
        w_buf_next        = r_buf;
        w_ifid_load       = 1'b0;
        w_ifid_flush      = 1'b0;
        w_ifid_d          = w_fetched;

        unique case (r_state)
            FETCH: begin
                if (br_taken) begin
                    w_pc_next    = br_addr;
                    w_ifid_flush = 1'b1;
                    if (!w_ack) begin
                        // Request still in flight: wait out its ack.
                        w_drain_addr_next = r_pc;
                        w_state_next      = DRAIN;
                    end
                end else if (w_ack) begin
                    w_pc_next = w_pc_inc;
                    if (freeze) begin
                        w_buf_next   = w_fetched;
                        w_state_next = HOLD;
                    end else begin
                        w_ifid_load = 1'b1;
                    end
                end else if (!freeze) begin
                    w_ifid_flush = 1'b1;
                end
            end

            HOLD: begin
                if (br_taken) begin
                    w_pc_next    = br_addr;
                    w_ifid_flush = 1'b1;
                    w_buf_next   = make_bubble(NOP_INSTR);
                    w_state_next = FETCH;
                end else if (!freeze) begin
                    w_ifid_d     = r_buf;
                    w_ifid_load  = 1'b1;
                    w_buf_next   = make_bubble(NOP_INSTR);
                    w_state_next = FETCH;
                end
            end

            DRAIN: begin
                if (br_taken) begin
                    w_pc_next    = br_addr;
                    w_ifid_flush = 1'b1;
                end else if (!freeze) begin
                    w_ifid_flush = 1'b1;
                end
                // The squashed request retires here; its data is dropped.
                if (w_ack) begin
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign if_pc          = w_ifid_q.pc;
    assign if_instruction = w_ifid_q.instr;
    assign if_valid       = w_ifid_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage. A responder models the
//            instruction memory with configurable latency; a reference model
//            tracks the fetch stream as a PC, a "stale request" flag and a
//            queue of parked words, and predicts IF/ID and bus outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .br_taken       (br_taken),
        .br_addr        (br_addr),
        .imem           (bus),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder
    int          mem_lat;
    int          mem_cnt;
    bit          spurious_en;
    bit          rand_lat;
    logic [31:0] word_q[$];

    // Reference model
    logic [31:0] m_pc;
    logic [31:0] m_stale_addr;
    bit          m_stale;
    word_t       held[$];
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;

    function automatic bit exp_req();
        return (rst === 1'b0) && (held.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    task automatic drive_mem();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        if (bus.imem_req === 1'b1) begin
            if (mem_cnt >= mem_lat) begin
                bus.imem_ack = 1'b1;
                if (word_q.size() > 0) bus.imem_rdata = word_q.pop_front();
            end
        end else if (spurious_en) begin
            bus.imem_ack = ($urandom_range(0, 3) == 0);
        end
    endtask

    // One clock: present memory response, clock the DUT, advance the model.
    task automatic cycle();
        bit          s_rst, s_fr, s_br, s_ack, s_req, s_dut_req, acked;
        logic [31:0] s_ba, s_rd;
        word_t       w;
        #1;
        drive_mem();
        s_rst     = rst;
        s_fr      = freeze;
        s_br      = br_taken;
        s_ba      = br_addr;
        s_ack     = bus.imem_ack;
        s_rd      = bus.imem_rdata;
        s_req     = (held.size() == 0);
        s_dut_req = bus.imem_req;
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        if (s_rst) begin
            mem_cnt = 0;
        end else if (s_dut_req) begin
            if (s_ack) begin
                mem_cnt = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                mem_cnt++;
            end
        end

        acked = s_ack && s_req;
        if (s_rst) begin
            m_pc = RESET_PC; m_stale = 0; held.delete();
            e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0;
        end else if (s_br) begin
            if (s_req && !acked) begin
                if (!m_stale) m_stale_addr = m_pc;
                m_stale = 1;
            end else begin
                m_stale = 0;
            end
            m_pc = s_ba;
            held.delete();
            e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0;
        end else if (m_stale) begin
            if (acked) m_stale = 0;
            if (!s_fr) begin e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0; end
        end else if (held.size() != 0) begin
            if (!s_fr) begin
                e_pc = held[0].pc; e_instr = held[0].instr; e_valid = 1'b1;
                held.delete();
            end
        end else if (acked) begin
            w.pc = m_pc + 32'd4;
            w.instr = s_rd;
            m_pc = m_pc + 32'd4;
            if (s_fr) held.push_back(w);
            else begin e_pc = w.pc; e_instr = w.instr; e_valid = 1'b1; end
        end else if (!s_fr) begin
            e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
        word_q.delete(); mem_lat = 0; spurious_en = 0; rand_lat = 0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
        mem_lat = 0; mem_cnt = 0; spurious_en = 0; rand_lat = 0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        cycle();
        cycle();
        n_checks++;
        if ({if_pc, if_instruction, if_valid} !== {32'h0, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ifid: got %h/%h/%b want 0/%h/0", if_pc, if_instruction, if_valid, NOP);
        end
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b want 0", bus.imem_req);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_ack_every_cycle();
        logic [31:0] words[2];
        words[0] = 32'h2001_0005;
        words[1] = 32'h2002_0006;
        do_reset();
        word_q.push_back(words[0]);
        word_q.push_back(words[1]);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if ({if_pc, if_instruction, if_valid} !== {32'(4 * (i + 1)), words[i], 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_ifid[%0d]: got %h/%h/%b want %h/%h/1", i, if_pc, if_instruction, if_valid, 32'(4 * (i + 1)), words[i]);
            end
            n_checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * (i + 1))) begin
                n_fail++;
                $display("FAIL b2b_addr[%0d]: got %b/%h want 1/%h", i, bus.imem_req, bus.imem_addr, 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_latency();
        int nvalid = 0;
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (if_valid === 1'b1) nvalid++;
            n_checks++;
            if ({if_pc, if_instruction, if_valid} !== {e_pc, e_instr, e_valid}
                || if_valid !== ((i % 3) == 2)) begin
                n_fail++;
                $display("FAIL latency_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, if_pc, if_instruction, if_valid, e_pc, e_instr, e_valid);
            end
            n_checks++;
            if (bus.imem_req !== exp_req() || bus.imem_addr !== exp_addr()
                || (i < 2 && bus.imem_addr !== 32'h0)) begin
                n_fail++;
                $display("FAIL latency_addr[%0d]: got %b/%h want %b/%h", i, bus.imem_req, bus.imem_addr, exp_req(), exp_addr());
            end
        end
        n_checks++;
        if (nvalid != 3) begin
            n_fail++;
            $display("FAIL latency_count: got %0d valid words want 3", nvalid);
        end
    endtask

    task automatic test_freeze();
        bit          fz[6];
        logic [31:0] w8;
        fz[0] = 0; fz[1] = 0; fz[2] = 1; fz[3] = 1; fz[4] = 1; fz[5] = 0;
        w8 = 32'hCAFE_0008;
        do_reset();
        word_q.push_back(32'h1111_0000);
        word_q.push_back(32'h1111_0004);
        word_q.push_back(w8);
        for (int i = 0; i < 6; i++) begin
            freeze = fz[i];
            cycle();
            n_checks++;
            if ({if_pc, if_instruction, if_valid} !== {e_pc, e_instr, e_valid}) begin
                n_fail++;
                $display("FAIL freeze_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, if_pc, if_instruction, if_valid, e_pc, e_instr, e_valid);
            end
            if (i >= 2 && i <= 4) begin
                n_checks++;
                if (if_pc !== 32'h8 || bus.imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL freeze_hold[%0d]: got pc=%h req=%b want 8/0", i, if_pc, bus.imem_req);
                end
            end
        end
        freeze = 1'b0;
        n_checks++;
        if ({if_pc, if_instruction, if_valid, bus.imem_req, bus.imem_addr} !== {32'hC, w8, 1'b1, 1'b1, 32'hC}) begin
            n_fail++;
            $display("FAIL freeze_release: got %h/%h/%b req=%b addr=%h want c/%h/1 1/c", if_pc, if_instruction, if_valid, bus.imem_req, bus.imem_addr, w8);
        end
    endtask

    task automatic test_branch_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mem_lat  = (i >= 4 && i <= 6) ? 2 : 0;
            br_taken = (i == 4);
            br_addr  = 32'h40;
            cycle();
            br_taken = 1'b0;
            n_checks++;
            if ({if_pc, if_instruction, if_valid} !== {e_pc, e_instr, e_valid}
                || (i >= 4 && i <= 6 && if_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL drain_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, if_pc, if_instruction, if_valid, e_pc, e_instr, e_valid);
            end
            if (i == 4 || i == 5) begin
                n_checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
                    n_fail++;
                    $display("FAIL drain_hold_addr[%0d]: got %b/%h want 1/10", i, bus.imem_req, bus.imem_addr);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
                    n_fail++;
                    $display("FAIL drain_target: got %b/%h want 1/40", bus.imem_req, bus.imem_addr);
                end
            end
        end
        n_checks++;
        if (if_pc !== 32'h44 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_first_valid: got pc=%h v=%b want 44/1", if_pc, if_valid);
        end
    endtask

    task automatic test_branch_in_hold();
        logic [31:0] w_new;
        w_new = 32'hBEEF_0080;
        do_reset();
        word_q.push_back(32'hDEAD_0000);
        word_q.push_back(w_new);
        freeze = 1'b1;
        cycle();
        br_taken = 1'b1; br_addr = 32'h80;
        cycle();
        br_taken = 1'b0; freeze = 1'b0;
        n_checks++;
        if ({if_pc, if_instruction, if_valid, bus.imem_req, bus.imem_addr} !== {32'h0, NOP, 1'b0, 1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL hold_branch: got %h/%h/%b req=%b addr=%h want 0/0/0 1/80", if_pc, if_instruction, if_valid, bus.imem_req, bus.imem_addr);
        end
        cycle();
        n_checks++;
        if ({if_pc, if_instruction, if_valid} !== {32'h84, w_new, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_branch_next: got %h/%h/%b want 84/%h/1", if_pc, if_instruction, if_valid, w_new);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        br_taken = 1'b1; br_addr = 32'hFFFF_FFF8;
        cycle();
        br_taken = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if ({if_pc, if_valid, bus.imem_addr} !== {32'h0, 1'b1, 32'h0} || if_instruction !== e_instr) begin
            n_fail++;
            $display("FAIL wrap: got pc=%h v=%b addr=%h want 0/1/0", if_pc, if_valid, bus.imem_addr);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        mem_lat = 3;
        br_taken = 1'b1; br_addr = 32'h100;
        cycle();
        br_taken = 1'b0;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_drain_pre: got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
        end
        rst = 1'b1;
        cycle();
        n_checks++;
        if ({if_pc, if_instruction, if_valid, bus.imem_req} !== {32'h0, NOP, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_drain_vals: got %h/%h/%b req=%b want 0/0/0 0", if_pc, if_instruction, if_valid, bus.imem_req);
        end
        rst = 1'b0;
        mem_lat = 0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rst_drain_req: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
        cycle();
        n_checks++;
        if (if_pc !== RESET_PC + 32'd4 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_drain_first: got pc=%h v=%b want %h/1", if_pc, if_valid, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_random();
        do_reset();
        spurious_en = 1;
        rand_lat    = 1;
        mem_lat     = 1;
        for (int i = 0; i < 800; i++) begin
            freeze   = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 11) == 0);
            br_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            rst      = ($urandom_range(0, 99) == 0);
            cycle();
            n_checks++;
            if ({if_pc, if_instruction, if_valid} !== {e_pc, e_instr, e_valid}) begin
                n_fail++;
                $display("FAIL random_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, if_pc, if_instruction, if_valid, e_pc, e_instr, e_valid);
            end
            n_checks++;
            if (bus.imem_req !== exp_req() || (exp_req() && bus.imem_addr !== exp_addr())) begin
                n_fail++;
                $display("FAIL random_bus[%0d]: got %b/%h want %b/%h", i, bus.imem_req, bus.imem_addr, exp_req(), exp_addr());
            end
        end
        rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; spurious_en = 0;
    endtask

    initial begin
        test_reset();
        test_ack_every_cycle();
        test_latency();
        test_freeze();
        test_branch_drain();
        test_branch_in_hold();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
